// File: rtl/wb_port_arbiter_if.sv
// Bundle of the two write requesters (P pipeline, L long-latency unit) and the
// register-file write port. The fwd_* bypass signals exist only with WB_FWD_EN.
interface wb_port_arbiter_if;
  // P: pipeline write-back requester
  logic        p_valid;
  logic        p_ready;
  logic [1:0]  p_sel;
  logic [31:0] p_pc;
  logic [31:0] p_alu;
  logic [31:0] p_mem;
  logic [31:0] p_imm;
  logic [4:0]  p_rd;
  // L: long-latency requester
  logic        l_valid;
  logic        l_ready;
  logic [31:0] l_data;
  logic [4:0]  l_rd;
  // Register-file write port
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  modport slave (
    input  p_valid, p_sel, p_pc, p_alu, p_mem, p_imm, p_rd,
    input  l_valid, l_data, l_rd,
`ifdef WB_FWD_EN
    output fwd_valid, fwd_rd, fwd_data,
`endif
    output p_ready, l_ready, rf_we, rf_rd, rf_wdata
  );

  modport master (
    output p_valid, p_sel, p_pc, p_alu, p_mem, p_imm, p_rd,
    output l_valid, l_data, l_rd,
`ifdef WB_FWD_EN
    input  fwd_valid, fwd_rd, fwd_data,
`endif
    input  p_ready, l_ready, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: P has default priority, L is protected from
// starvation (forced grant after MAX_WAIT cycles) and WAW reordering. Define WB_FWD_EN for fwd_* bypass outputs.
module wb_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4  // legal range 1..15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_port_arbiter_if.slave   bus
);

  typedef enum logic {NORMAL, FORCE_L} state_e;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [3:0] FORCE_AT  = 4'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        p_grant, l_grant;
  logic [31:0] p_data;

  always_comb begin
    unique case (bus.p_sel)
      2'd0: p_data = bus.p_pc;
      2'd1: p_data = bus.p_alu;
      2'd2: p_data = bus.p_mem;
      2'd3: p_data = bus.p_imm;
    endcase
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    p_grant    = 1'b0;
    l_grant    = 1'b0;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    // Nothing is accepted while in reset; requesters re-present afterwards.
    if (!rst_i) begin
      if (state_q == FORCE_L && bus.l_valid) begin
        l_grant = 1'b1;
      end else if (bus.l_valid && bus.p_valid &&
                   bus.l_rd == bus.p_rd && bus.l_rd != 5'd0) begin
        l_grant = 1'b1;  // L issued earlier: let it land first
      end else if (bus.p_valid) begin
        p_grant = 1'b1;
      end else if (bus.l_valid) begin
        l_grant = 1'b1;
      end
    end

    if (l_grant || !bus.l_valid) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    unique case (state_q)
      NORMAL:  if (bus.l_valid && !l_grant && wait_cnt_q == FORCE_AT) state_d = FORCE_L;
      FORCE_L: if (l_grant || !bus.l_valid) state_d = NORMAL;
    endcase

    if (p_grant) begin
      rf_we_d    = (bus.p_rd != 5'd0);
      rf_rd_d    = bus.p_rd;
      rf_wdata_d = p_data;
    end else if (l_grant) begin
      rf_we_d    = (bus.l_rd != 5'd0);
      rf_rd_d    = bus.l_rd;
      rf_wdata_d = bus.l_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= NORMAL;
      wait_cnt_q <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.p_ready  = p_grant;
  assign bus.l_ready  = l_grant;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_rd    = rf_rd_q;
  assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_FWD_EN
  assign bus.fwd_valid = rf_we_q;
  assign bus.fwd_rd    = rf_rd_q;
  assign bus.fwd_data  = rf_wdata_q;
`endif

endmodule
